// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the CPU multiplexed bus and its memory responder.
// Both sides import this so rom_ram polarity and state encodings agree.
package bus_mem_responder_pkg;

    localparam int BITS = 8;

    typedef enum logic {
        FETCH_ROM = 1'b0,
        FETCH_RAM = 1'b1
    } space_e;

    typedef enum logic {
        RSP_IDLE  = 1'b0,
        RSP_ARMED = 1'b1
    } rsp_state_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_ROM  = 2'd1,
        SRC_RAM  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/bus_mem_bank.sv
// Synchronous-write, registered-read word array.
// CLEAR selects whether the contents are zeroed by reset.
module bus_mem_bank #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter bit CLEAR = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    generate
        if (CLEAR) begin : g_clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem <= '{default: '0};
                end else if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

    // Read samples the pre-write contents when raddr == waddr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU's 8-bit multiplexed bus:
// address latch with auto-increment, ROM/RAM banks and a sticky fault flag.
module bus_mem_responder #(
    parameter int BITS      = bus_mem_responder_pkg::BITS,
    parameter int RAM_DEPTH = 16,
    parameter int ROM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] bus_in,
    input  logic            rom_ram,
    input  logic            addr_data,
    input  logic            write,
    input  logic            prog_we,
    input  logic [BITS-1:0] prog_addr,
    input  logic [BITS-1:0] prog_data,
    output logic [BITS-1:0] data_out,
    output logic            fault
);

    import bus_mem_responder_pkg::*;

    localparam int RAW = $clog2(RAM_DEPTH);
    localparam int OAW = $clog2(ROM_DEPTH);
    localparam logic [BITS:0] RAM_LIM = (BITS+1)'(RAM_DEPTH);

    rsp_state_e      state;
    space_e          space;
    space_e          rd_space;
    rd_src_e         src;
    rd_src_e         src_nxt;
    logic [BITS-1:0] addr;
    logic [BITS-1:0] rd_addr;
    logic [BITS-1:0] rom_q;
    logic [BITS-1:0] ram_q;
    logic            addr_ph;
    logic            data_ph;
    logic            rd_en;
    logic            ram_hit_rd;
    logic            ram_hit_cur;
    logic            rom_re;
    logic            ram_re;
    logic            ram_oob_rd;
    logic            wr_ram;
    logic            bad;

    always_comb begin
        addr_ph     = !addr_data;
        data_ph     = addr_data && (state == RSP_ARMED);
        rd_en       = addr_ph || data_ph;
        rd_addr     = addr_ph ? bus_in : addr + 1'b1;
        rd_space    = addr_ph ? space_e'(rom_ram) : space;
        ram_hit_rd  = {1'b0, rd_addr} < RAM_LIM;
        ram_hit_cur = {1'b0, addr} < RAM_LIM;
        rom_re      = rd_en && (rd_space == FETCH_ROM);
        ram_re      = rd_en && (rd_space == FETCH_RAM) && ram_hit_rd;
        ram_oob_rd  = rd_en && (rd_space == FETCH_RAM) && !ram_hit_rd;
        wr_ram      = data_ph && write && (space == FETCH_RAM) && ram_hit_cur;
    end

    // Protocol violations: orphan data phase, ROM write, RAM out of range.
    always_comb begin
        bad = 1'b0;
        if (addr_data && (state == RSP_IDLE)) begin
            bad = 1'b1;
        end
        if (data_ph && write && (space == FETCH_ROM)) begin
            bad = 1'b1;
        end
        if (data_ph && (space == FETCH_RAM) && !ram_hit_cur) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        src_nxt = src;
        unique case (1'b1)
            rom_re:     src_nxt = SRC_ROM;
            ram_re:     src_nxt = SRC_RAM;
            ram_oob_rd: src_nxt = SRC_ZERO;
            default:    src_nxt = src;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RSP_IDLE;
            addr  <= '0;
            space <= FETCH_ROM;
            src   <= SRC_ZERO;
            fault <= 1'b0;
        end else begin
            src <= src_nxt;
            if (addr_ph) begin
                addr  <= bus_in;
                space <= space_e'(rom_ram);
                state <= RSP_ARMED;
            end else if (data_ph) begin
                addr <= addr + 1'b1;
            end
            if (bad) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        unique case (src)
            SRC_ROM: data_out = rom_q;
            SRC_RAM: data_out = ram_q;
            default: data_out = '0;
        endcase
    end

    bus_mem_bank #(
        .W     (BITS),
        .DEPTH (ROM_DEPTH),
        .AW    (OAW),
        .CLEAR (1'b0)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .we    (prog_we),
        .waddr (prog_addr[OAW-1:0]),
        .wdata (prog_data),
        .re    (rom_re),
        .raddr (rd_addr[OAW-1:0]),
        .rdata (rom_q)
    );

    bus_mem_bank #(
        .W     (BITS),
        .DEPTH (RAM_DEPTH),
        .AW    (RAW),
        .CLEAR (1'b1)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ram),
        .waddr (addr[RAW-1:0]),
        .wdata (bus_in),
        .re    (ram_re),
        .raddr (rd_addr[RAW-1:0]),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: directed bus/program cycles,
// expected responses queued by the driver and checked by a monitor.
module tb_bus_mem_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] bus_in = '0;
    logic       rom_ram = 1'b0;
    logic       addr_data = 1'b0;
    logic       write = 1'b0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] data_out;
    logic       fault;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] d;
        logic       f;
        bit         fchk;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    bus_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .rom_ram   (rom_ram),
        .addr_data (addr_data),
        .write     (write),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .data_out  (data_out),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || data_out !== e.d ||
                (e.fchk && fault !== e.f)) begin
                errors++;
                $display("FAIL %s: data_out=%h fault=%b, required data_out=%h fault=%b",
                         e.name, data_out, fault, e.d, e.f);
            end
        end
    end

    task automatic drive(input bit r, input bit ad, input bit rr,
                         input bit wr, input logic [7:0] b,
                         input bit pw, input logic [7:0] pa,
                         input logic [7:0] pd);
        @(negedge clk);
        reset     = r;
        addr_data = ad;
        rom_ram   = rr;
        write     = wr;
        bus_in    = b;
        prog_we   = pw;
        prog_addr = pa;
        prog_data = pd;
    endtask

    task automatic chk(input string nm, input logic [7:0] d, input logic f);
        q.push_back('{cyc + 1, nm, d, f, 1'b1});
    endtask

    task automatic chkd(input string nm, input logic [7:0] d);
        q.push_back('{cyc + 1, nm, d, 1'b0, 1'b0});
    endtask

    task automatic rs();
        drive(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic ap(input bit rr, input logic [7:0] a);
        drive(0, 0, rr, 0, a, 0, 8'h00, 8'h00);
    endtask

    task automatic dr();
        drive(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic dw(input logic [7:0] b);
        drive(0, 1, 0, 1, b, 0, 8'h00, 8'h00);
    endtask

    task automatic pg(input logic [7:0] a, input logic [7:0] d);
        drive(0, 0, 0, 0, 8'h00, 1, a, d);
    endtask

    initial begin
        rs();  chk("reset_state", 8'h00, 1'b0);
        dr();  chk("idle_data_phase", 8'h00, 1'b1);
        rs();  chk("reset_clears_fault", 8'h00, 1'b0);

        pg(8'h00, 8'h11);
        pg(8'h01, 8'h22);
        pg(8'h02, 8'h33);
        pg(8'hFF, 8'h99);
        pg(8'h40, 8'h66);

        ap(0, 8'h00); chk("rom_addr0", 8'h11, 1'b0);
        dr();         chk("rom_burst1", 8'h22, 1'b0);
        dr();         chk("rom_burst2", 8'h33, 1'b0);

        ap(1, 8'h05); chk("ram5_cleared", 8'h00, 1'b0);
        dw(8'hA5);    chk("ram5_write_next", 8'h00, 1'b0);
        ap(1, 8'h05); chk("ram5_readback", 8'hA5, 1'b0);
        dr();         chk("ram6_after", 8'h00, 1'b0);

        ap(0, 8'hFF); chk("rom_ff", 8'h99, 1'b0);
        dr();         chk("rom_wrap_00", 8'h11, 1'b0);
        dr();         chk("rom_wrap_01", 8'h22, 1'b0);

        drive(0, 0, 0, 0, 8'h40, 1, 8'h40, 8'h77);
        chk("rom_read_before_prog", 8'h66, 1'b0);
        ap(0, 8'h40); chk("rom_after_prog", 8'h77, 1'b0);

        ap(0, 8'h01); chk("rom_01", 8'h22, 1'b0);
        dw(8'hEE);    chk("rom_write_fault", 8'h33, 1'b1);
        ap(0, 8'h01); chk("rom_unchanged", 8'h22, 1'b1);
        ap(1, 8'h05); chk("fault_sticky", 8'hA5, 1'b1);

        rs();         chk("reset_mid", 8'h00, 1'b0);
        ap(1, 8'h0F); chk("ram15", 8'h00, 1'b0);
        dw(8'hF1);    chk("ram15_write_edge", 8'h00, 1'b0);
        ap(1, 8'h0F); chk("ram15_readback", 8'hF1, 1'b0);
        ap(1, 8'h20); chkd("ram20_addr", 8'h00);
        dr();         chk("ram20_read_fault", 8'h00, 1'b1);

        rs();         chk("reset_clean", 8'h00, 1'b0);
        ap(1, 8'h03); chk("ram3_cleared", 8'h00, 1'b0);
        dw(8'h3C);    chk("ram3_wr", 8'h00, 1'b0);
        dw(8'h4D);    chk("ram4_wr", 8'h00, 1'b0);
        ap(1, 8'h03); chk("ram3_rb", 8'h3C, 1'b0);
        dr();         chk("ram4_rb", 8'h4D, 1'b0);
        ap(1, 8'h07); chk("ram7", 8'h00, 1'b0);
        dw(8'h7E);    chk("ram7_wr", 8'h00, 1'b0);
        rs();         chk("reset_burst", 8'h00, 1'b0);
        ap(1, 8'h03); chk("ram3_after_rst", 8'h00, 1'b0);
        ap(1, 8'h07); chk("ram7_after_rst", 8'h00, 1'b0);
        ap(0, 8'h02); chk("rom_retained", 8'h33, 1'b0);

        ap(0, 8'h00);
        ap(0, 8'h00);
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
